path_trace_sequencer: RTL and testbench
=======================================

// Module: path_trace_sequencer
// PURPOSE
//  Walks the predecessor table of pipelined_bellman_ford from a destination back to the source after compute completes.
//  Stacks the visited nodes, then streams them source-first to the VGA path writer over a valid/ready handshake.
//  Replaces the combinational RECURSION loop in the top FSM with a bounded, registered sequencer that has explicit error reporting.
// PARAMETERS
//  NODE_W    5   node index width; table holds 2**NODE_W entries, node 0 = "no predecessor" sentinel
//  MAX_HOPS  31  maximum predecessor reads per trace before loop-guard error
// PORTS
//  clk           in   1       system clock (50 MHz domain)
//  sys_reset     in   1       asynchronous, active-low reset
//  start         in   1       one-cycle pulse; accepted only in IDLE
//  source_addr   in   NODE_W  source node, sampled on accepted start
//  dest_addr     in   NODE_W  destination node, sampled on accepted start
//  pred_rd_en    out  1       predecessor read strobe
//  pred_rd_addr  out  NODE_W  predecessor table read address
//  pred_rd_data  in   NODE_W  predecessor of pred_rd_addr, valid 1 cycle after pred_rd_en
//  node_valid    out  1       path node available for the VGA writer
//  node_data     out  NODE_W  path node, source first, destination last
//  node_ready    in   1       VGA writer accepts node (transfer = node_valid & node_ready)
//  busy          out  1       high in every state except IDLE
//  done          out  1       one-cycle pulse after the last node transfers
//  error         out  1       sticky until next accepted start; trace aborted
//  hop_count     out  NODE_W  predecessor reads issued in current trace
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; stack empty; latched src/dst = 0.
//  States:
//   IDLE  -> on start: latch src/dst, push dst, clear hop_count and error.
//             If dst==src, go EMIT; otherwise cur=dst and go ISSUE.
//   ISSUE -> pred_rd_en=1, pred_rd_addr=cur, hop_count++; go WAIT.
//   WAIT  -> 1-cycle read latency; go CHECK.
//   CHECK -> p = pred_rd_data:
//             - p==src: push src; go EMIT.
//             - p==0 (src!=0): unreachable; go ERR.
//             - stack full: go ERR.
//             - otherwise push p, cur=p; go ISSUE.
//   EMIT  -> node_valid=1, node_data=stack top. On transfer, pop.
//             When the final entry transfers, go DONE.
//             node_data is held stable while node_valid & !node_ready.
//   DONE  -> done=1 for one cycle; go IDLE.
//   ERR   -> error=1; stack cleared; go IDLE. No nodes are emitted.
//  Latency (node_ready tied high): N-hop path = 1 + 3N cycles to first node_valid, then 1 node/cycle.
//  start while busy: ignored; no effect on the trace in progress.
//  Stack: LIFO, depth 2**NODE_W. A push when full is an overflow, reported through ERR.
//  hop_count saturates at 2**NODE_W-1 and never wraps.
//  Async reset mid-trace: immediate return to IDLE with the stack emptied; no done or error pulse.
//  error and done are never high in the same cycle.
// CONFIGURATION
//  PATH_TRACE_LOOP_GUARD_EN defined:
//   - in CHECK, hop_count==MAX_HOPS with p!=src -> ERR.
//   - detects negative-cycle or corrupt predecessor chains early.
//  Not defined:
//   - no hop limit; only the stack-full overflow terminates a cyclic chain, via ERR.
// STRUCTURE
//  bf_pkg: NODE_W constant, NULL_NODE=0, trace_state_t enum {IDLE,ISSUE,WAIT,CHECK,EMIT,DONE,ERR}.
//  Sub-module path_stack:
//   - parameterised LIFO with push, pop, clear, top, full and empty.
//   - registered storage, asynchronous reset.
//  The sequencer holds the FSM, latches, hop counter and handshake logic only.
// TESTING
//  1. Pred table 7->4, 4->2, 2->1 (src=1, dst=7), ready high:
//     -> nodes 1,2,4,7, then done.
//     -> hop_count=3; first node_valid 10 cycles after start.
//  2. dst==src==3:
//     -> single node 3, done; no pred_rd_en ever asserted.
//  3. Pred 9->0, src=1, dst=9:
//     -> error=1, no node_valid, done never pulses.
//  4. Cyclic table 5->6, 6->5, src=1, dst=5, PATH_TRACE_LOOP_GUARD_EN defined:
//     -> error after 31 reads.
//     -> without the macro: error on stack-full at 32 entries.
//  5. Case 1 with node_ready toggling 0/1 each cycle:
//     -> node_data stable while stalled; same 4-node order.
//     -> start pulsed mid-EMIT is ignored.
//  6. sys_reset asserted during WAIT of case 1:
//     -> all outputs 0 immediately.
//     -> a fresh start reproduces case 1 exactly.

Source files
------------

// File: rtl/bf_pkg.sv
// bf_pkg: shared node width, null-node sentinel and trace FSM state encoding
// for the predecessor-path trace sequencer.
package bf_pkg;
    localparam int NODE_W = 5;
    localparam logic [NODE_W-1:0] NULL_NODE = '0;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, EMIT, DONE, ERR} trace_state_t;
endpackage

// File: rtl/path_stack.sv
// path_stack: registered LIFO holding traced path nodes; top is the most recent push.
module path_stack #(
    parameter int W          = 5,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_top,
    output logic         o_full,
    output logic         o_empty,
    output logic         o_last
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    logic [W-1:0]          r_mem [DEPTH];
    logic [DEPTH_LOG2:0]   r_cnt;
    logic [DEPTH_LOG2-1:0] w_top_idx;
    assign w_top_idx = DEPTH_LOG2'(r_cnt - 1'b1);
    assign o_top     = r_mem[w_top_idx];
    assign o_full    = r_cnt == (DEPTH_LOG2 + 1)'(DEPTH);
    assign o_empty   = r_cnt == '0;
    assign o_last    = r_cnt == (DEPTH_LOG2 + 1)'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_push && !o_full) begin
            r_mem[r_cnt[DEPTH_LOG2-1:0]] <= i_data;
            r_cnt <= r_cnt + 1'b1;
        end else if (i_pop && !o_empty) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end
endmodule

// File: rtl/path_trace_sequencer.sv
// path_trace_sequencer: walks the predecessor table from dest back to source, then streams the
// path source-first over valid/ready. Define PATH_TRACE_LOOP_GUARD_EN to abort after MAX_HOPS reads.
module path_trace_sequencer #(
    parameter int NODE_W   = 5,
    parameter int MAX_HOPS = 31
) (
    input  logic              clk,
    input  logic              sys_reset,
    input  logic              start,
    input  logic [NODE_W-1:0] source_addr,
    input  logic [NODE_W-1:0] dest_addr,
    output logic              pred_rd_en,
    output logic [NODE_W-1:0] pred_rd_addr,
    input  logic [NODE_W-1:0] pred_rd_data,
    output logic              node_valid,
    output logic [NODE_W-1:0] node_data,
    input  logic              node_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [NODE_W-1:0] hop_count
);
    import bf_pkg::*;
`ifdef PATH_TRACE_LOOP_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif
    localparam logic [NODE_W-1:0] HOP_SAT = '1;
    trace_state_t      r_state, w_next;
    logic [NODE_W-1:0] r_src, r_cur, r_hops, w_top, w_push_data;
    logic              r_error, w_push, w_pop, w_clear, w_full, w_empty, w_last, w_guard, w_found;
    assign w_guard = GUARD_EN && int'(r_hops) == MAX_HOPS;
    assign w_found = pred_rd_data == r_src;
    always_comb begin
        w_next      = r_state;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_clear     = 1'b0;
        w_push_data = r_state == IDLE ? dest_addr : pred_rd_data;
        case (r_state)
            IDLE: if (start) begin
                w_push = 1'b1;
                w_next = dest_addr == source_addr ? EMIT : ISSUE;
            end
            ISSUE: w_next = WAIT;
            WAIT:  w_next = CHECK;
            CHECK: begin
                // a full stack rejects every push, including the source itself
                if (w_full || (!w_found && (pred_rd_data == NULL_NODE || w_guard))) w_next = ERR;
                else begin
                    w_push = 1'b1;
                    w_next = w_found ? EMIT : ISSUE;
                end
            end
            EMIT: if (node_ready && !w_empty) begin
                w_pop  = 1'b1;
                w_next = w_last ? DONE : EMIT;
            end
            DONE: w_next = IDLE;
            ERR: begin
                w_clear = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_cur   <= '0;
            r_hops  <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_src   <= source_addr;
                r_cur   <= dest_addr;
                r_hops  <= '0;
                r_error <= 1'b0;
            end
            if (r_state == ISSUE && r_hops != HOP_SAT) r_hops <= r_hops + 1'b1;
            if (r_state == CHECK) r_cur <= pred_rd_data;
            if (w_next == ERR) r_error <= 1'b1;
        end
    end
    path_stack #(.W(NODE_W), .DEPTH_LOG2(NODE_W)) u_stack (
        .clk     (clk),
        .rst_n   (sys_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .i_data  (w_push_data),
        .o_top   (w_top),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_last  (w_last)
    );
    assign pred_rd_en   = r_state == ISSUE;
    assign pred_rd_addr = pred_rd_en ? r_cur : '0;
    assign node_valid   = r_state == EMIT;
    assign node_data    = node_valid ? w_top : '0;
    assign busy         = r_state != IDLE;
    assign done         = r_state == DONE;
    assign error        = r_error;
    assign hop_count    = r_hops;
endmodule

// File: tb/tb_path_trace_sequencer.sv
// tb_path_trace_sequencer: directed and randomized traces against a chain-walking reference model.
module tb_path_trace_sequencer;
    logic       clk = 1'b0, sys_reset = 1'b0, start = 1'b0, node_ready = 1'b0;
    logic [4:0] source_addr = '0, dest_addr = '0, pred_rd_data = '0;
    logic       pred_rd_en, node_valid, busy, done, error;
    logic [4:0] pred_rd_addr, node_data, hop_count;
    logic [4:0] tbl [32];
    int vecs = 0, errs = 0;

    path_trace_sequencer dut (
        .clk(clk), .sys_reset(sys_reset), .start(start), .source_addr(source_addr),
        .dest_addr(dest_addr), .pred_rd_en(pred_rd_en), .pred_rd_addr(pred_rd_addr),
        .pred_rd_data(pred_rd_data), .node_valid(node_valid), .node_data(node_data),
        .node_ready(node_ready), .busy(busy), .done(done), .error(error), .hop_count(hop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (pred_rd_en) pred_rd_data <= tbl[pred_rd_addr];

    task automatic check(input string tag, input int got, input int exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Follow the predecessor chain from d; the trace succeeds only if s appears within 31 reads
    // (stack of 32 entries), otherwise it fails at a null node or the read limit.
    task automatic model(input logic [4:0] s, input logic [4:0] d, output bit ok, output int reads,
                         output logic [4:0] path[$]);
        logic [4:0] ch[$];
        int k, lim;
`ifdef PATH_TRACE_LOOP_GUARD_EN
        lim = 31;
`else
        lim = 32;
`endif
        ch = {d};
        k = 0;
        if (s != d)
            for (int i = 1; i <= 40; i++) begin
                ch.push_back(tbl[ch[i-1]]);
                if (ch[i] == s || ch[i] == 0) begin
                    k = i;
                    break;
                end
            end
        ok    = (s == d) || (k != 0 && ch[k] == s && k <= 31);
        reads = ok ? k : ((k != 0 && k < lim) ? k : lim);
        path  = {};
        if (ok) for (int i = k; i >= 0; i--) path.push_back(ch[i]);
    endtask

    // mode: 0 ready high, 1 ready toggling, 2 ready random; poke pulses start mid-EMIT
    task automatic run_trace(input logic [4:0] s, input logic [4:0] d, input int mode, input bit poke);
        logic [4:0] exp_path[$], got[$], held;
        bit ok, fin, saw_done, stalled, poked;
        int reads, exp_reads, first, n;
        model(s, d, ok, exp_reads, exp_path);
        @(posedge clk); #1;
        source_addr = s; dest_addr = d; start = 1'b1; node_ready = 1'b0;
        n = 0; first = -1; reads = 0; fin = 0; saw_done = 0; stalled = 0; poked = 0; held = '0;
        got = {};
        while (!fin && n < 3000) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (pred_rd_en) reads++;
            if (node_valid && first < 0) first = n;
            if (stalled) begin
                check("stall_valid", node_valid, 1);
                check("stall_hold", node_data, held);
            end
            if (done && error) check("done_and_error", 1, 0);
            if (done) saw_done = 1;
            if (!busy) fin = 1;
            if (poke && node_valid && !poked) begin
                poked = 1;
                start = 1'b1;
                source_addr = s + 5'd3;
                dest_addr = d + 5'd7;
            end
            node_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'(n & 1) : 1'($urandom_range(0, 1));
            if (node_valid && node_ready) got.push_back(node_data);
            stalled = node_valid && !node_ready;
            held = node_data;
        end
        node_ready = 1'b0;
        check("finished", fin, 1);
        check("error", error, !ok);
        check("done_seen", saw_done, ok);
        check("hop_count", hop_count, exp_reads > 31 ? 31 : exp_reads);
        check("reads", reads, exp_reads);
        check("first_valid", first, ok ? 3 * exp_reads + 1 : -1);
        check("path_len", got.size(), exp_path.size());
        foreach (exp_path[i]) check($sformatf("node%0d", i), i < got.size() ? int'(got[i]) : -1, exp_path[i]);
    endtask

    task automatic clear_tbl();
        foreach (tbl[i]) tbl[i] = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rd_en"}, pred_rd_en, 0);
        check({tag, "_rd_addr"}, pred_rd_addr, 0);
        check({tag, "_valid"}, node_valid, 0);
        check({tag, "_data"}, node_data, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_hops"}, hop_count, 0);
    endtask

    initial begin
        logic [4:0] c, nx, s, d;
        int len;
        clear_tbl();
        #12;
        check_idle_outputs("reset");
        @(negedge clk) sys_reset = 1'b1;
        // case 1: 7->4->2->1
        tbl[7] = 5'd4; tbl[4] = 5'd2; tbl[2] = 5'd1;
        run_trace(5'd1, 5'd7, 0, 0);
        // case 2: dst == src
        run_trace(5'd3, 5'd3, 0, 0);
        // case 3: unreachable
        clear_tbl();
        run_trace(5'd1, 5'd9, 0, 0);
        // case 4: cycle 5 <-> 6
        tbl[5] = 5'd6; tbl[6] = 5'd5;
        run_trace(5'd1, 5'd5, 0, 0);
        // case 5: toggling ready with a mid-EMIT start
        clear_tbl();
        tbl[7] = 5'd4; tbl[4] = 5'd2; tbl[2] = 5'd1;
        run_trace(5'd1, 5'd7, 1, 1);
        // case 6: reset during WAIT, then the same trace again
        @(posedge clk); #1;
        source_addr = 5'd1; dest_addr = 5'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        sys_reset = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(negedge clk) sys_reset = 1'b1;
        run_trace(5'd1, 5'd7, 0, 0);
        // randomized tables, often seeded with a chain from dst towards src
        for (int t = 0; t < 60; t++) begin
            foreach (tbl[i]) tbl[i] = 5'($urandom_range(0, 31));
            s = 5'($urandom_range(0, 31));
            d = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) begin
                len = $urandom_range(1, 10);
                c = d;
                for (int j = 0; j < len; j++) begin
                    nx = (j == len - 1) ? s : 5'($urandom_range(1, 31));
                    tbl[c] = nx;
                    c = nx;
                end
            end
            run_trace(s, d, 2, t % 4 == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
